// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control sequencer.
// Holds the opcode values, IR field positions, the state encoding and the opcode classifier.
// Imported by ir_decode and control_unit.
package cpu_ctrl_pkg;

  // Opcodes (ir[31:27])
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // IR field bit positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI  = 26;
  localparam int RA_LO  = 23;
  localparam int RB_HI  = 22;
  localparam int RB_LO  = 19;
  localparam int RC_HI  = 18;
  localparam int RC_LO  = 15;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_T0     = 4'd1,
    ST_T1     = 4'd2,
    ST_T2     = 4'd3,
    ST_T3     = 4'd4,
    ST_T4     = 4'd5,
    ST_T5     = 4'd6,
    ST_T6     = 4'd7,
    ST_HALTED = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU3    = 3'd0,
    CLS_MULDIV  = 3'd1,
    CLS_NOP     = 3'd2,
    CLS_HALT    = 3'd3,
    CLS_ILLEGAL = 3'd4
  } op_class_e;

  function automatic op_class_e op_class(input logic [4:0] opc);
    op_class_e cls;
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_ROR, OP_ROL, OP_SHRA, OP_SHL: cls = CLS_ALU3;
      OP_MUL, OP_DIV:                  cls = CLS_MULDIV;
      OP_NOP:                          cls = CLS_NOP;
      OP_HALT:                         cls = CLS_HALT;
      default:                         cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/ir_decode.sv
// Combinational IR field decoder: opcode class plus one-hot ra/rb/rc register selects.
// Ports: ir (in, 32) -> opcode (5), op_cls (class), ra_oh/rb_oh/rc_oh (16 each, one-hot).
// Zero latency; no state.
module ir_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  opcode,
  output op_class_e   op_cls,
  output logic [15:0] ra_oh,
  output logic [15:0] rb_oh,
  output logic [15:0] rc_oh
);

  // Immediate/constant field below rc is not used by this sequencer.
  logic unused_ir;
  assign unused_ir = ^ir[RC_LO-1:0];

  always_comb begin
    opcode = ir[OPC_HI:OPC_LO];
    op_cls = op_class(ir[OPC_HI:OPC_LO]);
    ra_oh  = 16'd1 << ir[RA_HI:RA_LO];
    rb_oh  = 16'd1 << ir[RB_HI:RB_LO];
    rc_oh  = 16'd1 << ir[RC_HI:RC_LO];
  end

endmodule

// File: rtl/control_unit.sv
// Moore sequencer producing datapath control strobes over the fixed T0..T6 micro-step schedule.
// Ports: clock, clear (async active-high), run, mem_ready, ir[31:0] in; reg_in/reg_out one-hot,
// datapath strobes, alu_op, busy, halted, illegal out. Outputs decode from the state register and ir.
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic [15:0] reg_in,
  output logic [15:0] reg_out,
  output logic        PCout,
  output logic        IncPC,
  output logic        MARin,
  output logic        memRead,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIin,
  output logic        LOin,
  output logic        HIout,
  output logic        LOout,
  output logic [4:0]  alu_op,
  output logic        busy,
  output logic        halted,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic        illegal_q, illegal_d;
  logic [4:0]  opcode;
  op_class_e   op_cls;
  logic [15:0] ra_oh, rb_oh, rc_oh;

  ir_decode u_ir_decode (
    .ir     (ir),
    .opcode (opcode),
    .op_cls (op_cls),
    .ra_oh  (ra_oh),
    .rb_oh  (rb_oh),
    .rc_oh  (rc_oh)
  );

  // Next state. run is only consulted in IDLE and on the last step of an instruction.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: state_d = run ? ST_T0 : ST_IDLE;
      ST_T0:   state_d = ST_T1;
      ST_T1:   state_d = mem_ready ? ST_T2 : ST_T1;
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        case (op_cls)
          CLS_ALU3, CLS_MULDIV: state_d = ST_T4;
          CLS_NOP:              state_d = run ? ST_T0 : ST_IDLE;
          CLS_HALT: begin
            state_d   = ST_HALTED;
            illegal_d = 1'b0;
          end
          default: begin
            state_d   = ST_HALTED;
            illegal_d = 1'b1;
          end
        endcase
      end
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = (op_cls == CLS_MULDIV) ? ST_T6 : (run ? ST_T0 : ST_IDLE);
      ST_T6:   state_d = run ? ST_T0 : ST_IDLE;
      ST_HALTED: state_d = ST_HALTED;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= ST_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Strobe decode. IDLE (the reset state) leaves every output at its 0 default,
  // so clear forces all outputs low without waiting for a clock.
  always_comb begin
    reg_in   = '0;
    reg_out  = '0;
    PCout    = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    memRead  = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    HIout    = 1'b0;
    LOout    = 1'b0;
    alu_op   = 5'd0;
    case (state_q)
      ST_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
      end
      ST_T1: begin
        memRead = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        if (op_cls == CLS_ALU3) begin
          reg_out = rb_oh;
          Yin     = 1'b1;
        end else if (op_cls == CLS_MULDIV) begin
          reg_out = ra_oh;
          Yin     = 1'b1;
        end
      end
      ST_T4: begin
        if (op_cls == CLS_ALU3) begin
          reg_out = rc_oh;
          Zin     = 1'b1;
          alu_op  = opcode;
        end else if (op_cls == CLS_MULDIV) begin
          reg_out = rb_oh;
          Zin     = 1'b1;
          alu_op  = opcode;
        end
      end
      ST_T5: begin
        if (op_cls == CLS_ALU3) begin
          Zlowout = 1'b1;
          reg_in  = ra_oh;
        end else if (op_cls == CLS_MULDIV) begin
          Zlowout = 1'b1;
          LOin    = 1'b1;
        end
      end
      ST_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALTED);
  assign halted  = (state_q == ST_HALTED);
  assign illegal = (state_q == ST_HALTED) && illegal_q;

endmodule
